// File: rtl/uart_periph_if.sv
// CPU-side address and strobe bundle for uart_periph; the 8-bit data bus is a
// separate inout net because it is shared with the CPU.
interface uart_periph_if;
  // Bus protocol: we is a one-posedge write strobe, sampled with addr and data.
  // re=1 means the CPU has released data, so a selected peripheral may drive it.
  logic [15:0] addr;
  logic        re;
  logic        we;

  modport master (output addr, output re, output we);
  modport slave  (input addr, input re, input we);
endinterface

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TX FIFO, baud divider and transmit FSM, plus an
// optional receiver built only when UART_RX_EN is defined.
module uart_periph #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          PRESCALE     = 1,
  parameter logic [7:0]  BAUD_DIV_RST = 8'd103
) (
  input  logic         clk,
  input  logic         rst,
  uart_periph_if.slave bus,
  inout  wire  [7:0]   data,
  input  logic         rx,
  output logic         tx,
  output logic [1:0]   dbg_tx_state,
  output logic [1:0]   dbg_rx_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic          sel, wr_en, rd_en;
  logic [7:0]    rdata, status, baud;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty, push, tx_ovf, tx_busy;
  tx_state_t     tx_state;
  logic [7:0]    tx_shift;
  logic [2:0]    tx_bits;
  logic [PW-1:0] pre_cnt;
  logic [7:0]    baud_cnt;
  logic          pre_tick, bit_done;
  logic          rx_valid, rx_ovf, frame_err;
  logic [7:0]    rx_data;

  assign sel        = (bus.addr[15:2] == BASE_ADDR[15:2]);
  assign wr_en      = sel && bus.we;
  assign rd_en      = sel && bus.re;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = wr_en && (bus.addr[1:0] == 2'd0) && !fifo_full;
  assign tx_busy    = (tx_state != TX_IDLE);
  assign pre_tick   = (pre_cnt == PW'(PRESCALE - 1));
  assign bit_done   = pre_tick && (baud_cnt == 8'd0);
  assign dbg_tx_state = tx_state;

  assign status = {1'b0, frame_err, rx_ovf, rx_valid, tx_ovf, tx_busy, fifo_empty, fifo_full};

  always_comb begin
    rdata = 8'h00;
    case (bus.addr[1:0])
      2'd1:    rdata = status;
      2'd2:    rdata = rx_data;
      2'd3:    rdata = baud;
      default: rdata = 8'h00;
    endcase
  end

  assign data = rd_en ? rdata : 8'bz;

  // CPU write side: FIFO push, overflow flag and the divisor register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      tx_ovf <= 1'b0;
      baud   <= BAUD_DIV_RST;
    end else if (wr_en) begin
      case (bus.addr[1:0])
        2'd0: begin
          if (fifo_full) tx_ovf <= 1'b1;
          else           wr_ptr <= wr_ptr + 1'b1;
        end
        2'd1:    if (data[3]) tx_ovf <= 1'b0;
        2'd3:    baud <= data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

  // Transmit FSM; the divider reloads from baud at every bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_shift <= 8'h00;
      tx_bits  <= 3'd0;
      rd_ptr   <= '0;
      pre_cnt  <= '0;
      baud_cnt <= 8'd0;
    end else begin
      if (tx_state != TX_IDLE) begin
        if (pre_tick) begin
          pre_cnt <= '0;
          if (baud_cnt == 8'd0) baud_cnt <= baud;
          else                  baud_cnt <= baud_cnt - 8'd1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
      case (tx_state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_shift <= mem[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
            tx_bits  <= 3'd0;
            pre_cnt  <= '0;
            baud_cnt <= baud;
            tx       <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (bit_done) begin
            tx       <= tx_shift[0];
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            if (tx_bits == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bits  <= tx_bits + 3'd1;
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
            end
          end
        end
        TX_STOP: if (bit_done) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [23:0] rx_cnt, rx_period, rx_half;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift;

  assign rx_period    = 24'(PRESCALE) * (24'(baud) + 24'd1);
  // Edge detection already sits one clock behind s2, so the half-bit wait is shortened.
  assign rx_half      = (rx_period >= 24'd4) ? (rx_period >> 1) - 24'd2 : 24'd0;
  assign dbg_rx_state = rx_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= 24'd0;
      rx_bits   <= 3'd0;
      rx_shift  <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_ovf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (wr_en && bus.addr[1:0] == 2'd1) begin
        if (data[5]) rx_ovf    <= 1'b0;
        if (data[6]) frame_err <= 1'b0;
      end
      if (wr_en && bus.addr[1:0] == 2'd2) rx_valid <= 1'b0;
      // Later assignments below let a delivery override a same-edge CPU clear.
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= rx_half;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt != 24'd0) rx_cnt <= rx_cnt - 24'd1;
          else if (!rx_s2) begin
            rx_cnt   <= rx_period - 24'd1;
            rx_bits  <= 3'd0;
            rx_state <= RX_DATA;
          end else rx_state <= RX_IDLE;
        end
        RX_DATA: begin
          if (rx_cnt != 24'd0) rx_cnt <= rx_cnt - 24'd1;
          else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= rx_period - 24'd1;
            if (rx_bits == 3'd7) rx_state <= RX_STOP;
            else                 rx_bits  <= rx_bits + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt != 24'd0) rx_cnt <= rx_cnt - 24'd1;
          else begin
            if (!rx_s2) frame_err <= 1'b1;
            if (rx_valid) rx_ovf  <= 1'b1;
            else          rx_data <= rx_shift;
            rx_valid <= 1'b1;
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
`else
  logic unused_rx;

  assign unused_rx    = rx;
  assign rx_valid     = 1'b0;
  assign rx_ovf       = 1'b0;
  assign frame_err    = 1'b0;
  assign rx_data      = 8'h00;
  assign dbg_rx_state = 2'd0;
`endif

endmodule

// File: tb/tb_uart_periph.sv
// Bench for uart_periph: queue-based frame model compared every cycle, plus
// directed literal checks of reset, framing, overflow, RX and isolation.
`timescale 1ns/1ps
module tb_uart_periph;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 4;
  localparam int          PRE   = 1;

  logic       clk, rst, rx, tx, cpu_drive;
  logic [7:0] cpu_data;
  logic [1:0] dbg_tx_state, dbg_rx_state;
  wire  [7:0] data;
  int         checks, errors;

  uart_periph_if bif ();

  assign data = cpu_drive ? cpu_data : 8'bz;

  uart_periph #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .PRESCALE(PRE), .BAUD_DIV_RST(8'd103)
  ) dut (
    .clk(clk), .rst(rst), .bus(bif.slave), .data(data), .rx(rx), .tx(tx),
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: software FIFO of bytes plus the per-clock line levels of the frame in flight.
  logic [7:0] m_fifo[$];
  logic       m_lvl[$];
  logic       m_ovf;
  logic [7:0] m_baud;

  always @(posedge clk or posedge rst) begin
    logic       idle;
    int         pre_n;
    logic [7:0] b;
    logic       lv;
    if (rst) begin
      m_fifo.delete();
      m_lvl.delete();
      m_ovf  = 1'b0;
      m_baud = 8'd103;
    end else begin
      idle  = (m_lvl.size() == 0);
      pre_n = m_fifo.size();
      if (idle && pre_n > 0) begin
        b = m_fifo.pop_front();
        for (int s = 0; s < 10; s++) begin
          lv = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
          for (int k = 0; k < PRE * (int'(m_baud) + 1); k++) m_lvl.push_back(lv);
        end
      end else if (!idle) begin
        void'(m_lvl.pop_front());
      end
      if (bif.we && bif.addr[15:2] == BASE[15:2]) begin
        case (bif.addr[1:0])
          2'd0: if (pre_n == DEPTH) m_ovf = 1'b1; else m_fifo.push_back(cpu_data);
          2'd1: if (cpu_data[3]) m_ovf = 1'b0;
          2'd3: m_baud = cpu_data;
          default: ;
        endcase
      end
    end
  end

  function automatic logic m_tx();
    return (m_lvl.size() != 0) ? m_lvl[0] : 1'b1;
  endfunction

  function automatic logic [7:0] m_status();
    return {4'b0000, m_ovf, m_lvl.size() != 0, m_fifo.size() == 0, m_fifo.size() == DEPTH};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_step();
    logic [7:0] mask;
`ifdef UART_RX_EN
    mask = 8'h8F;
`else
    mask = 8'hFF;
`endif
    check8("model_tx", {7'd0, tx}, {7'd0, m_tx()});
    if (bif.re && bif.addr[15:2] == BASE[15:2]) begin
      case (bif.addr[1:0])
        2'd0: check8("model_txdata_rd", data, 8'h00);
        2'd1: check8("model_status", data & mask, m_status() & mask);
        2'd3: check8("model_baud", data, m_baud);
        default: ;
      endcase
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    bif.addr = a; cpu_data = v; cpu_drive = 1'b1; bif.re = 1'b0; bif.we = 1'b1;
    @(posedge clk); #1;
    bif.we = 1'b0; cpu_drive = 1'b0; bif.re = 1'b1; bif.addr = 16'h0100;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
    @(posedge clk); #1;
    bif.addr = a; bif.re = 1'b1; cpu_drive = 1'b0;
    @(negedge clk);
    v = data;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (4) @(posedge clk);
    end
    #1 rx = stop;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  logic [7:0] v;
  logic [9:0] fr;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; rx = 1'b1; cpu_drive = 1'b0; cpu_data = 8'h00;
    bif.addr = 16'h0100; bif.re = 1'b1; bif.we = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare_step();
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check8("reset_tx", {7'd0, tx}, 8'h01);
    @(posedge clk); #1 rst = 1'b0;
    bus_read(16'hFF01, v); check8("reset_status", v, 8'h02);
    bus_read(16'hFF03, v); check8("reset_baud", v, 8'h67);
    bus_read(16'h0100, v);
    checks++;
    if (data !== 8'hzz) begin errors++; $display("FAIL data_z_unsel: got %h expected zz", data); end

    // Bus isolation
    @(posedge clk); #1 bif.addr = 16'hFF01; bif.re = 1'b0; cpu_drive = 1'b0;
    @(negedge clk);
    checks++;
    if (data !== 8'hzz) begin errors++; $display("FAIL data_z_re0: got %h expected zz", data); end
    bus_write(16'hFE00, 8'h77);
    repeat (3) @(posedge clk);
    bus_read(16'hFF01, v); check8("iso_status", v, 8'h02);

    // Single frame 0xA5, BAUD=3
    fr = {1'b1, 8'hA5, 1'b0};
    bus_write(16'hFF03, 8'h03);
    bus_write(16'hFF00, 8'hA5);
    bif.addr = 16'hFF01;
    @(negedge clk);
    check8("prepop_tx", {7'd0, tx}, 8'h01);
    check8("prepop_status", data, 8'h00);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check8("a5_tx", {7'd0, tx}, {7'd0, fr[i/4]});
      check8("a5_status", data, 8'h06);
    end
    @(negedge clk);
    check8("a5_after_tx", {7'd0, tx}, 8'h01);
    check8("a5_after_status", data, 8'h02);

    // Back-to-back frames: exactly one idle clock between them
    bus_write(16'hFF00, 8'h3C);
    bus_write(16'hFF00, 8'hC3);
    bif.addr = 16'hFF01;
    repeat (39) @(negedge clk);
    check8("b2b_stop_tx", {7'd0, tx}, 8'h01);
    @(negedge clk);
    check8("b2b_gap_tx", {7'd0, tx}, 8'h01);
    check8("b2b_gap_status", data, 8'h00);
    @(negedge clk);
    check8("b2b_start_tx", {7'd0, tx}, 8'h00);
    check8("b2b_start_status", data, 8'h06);
    repeat (45) @(posedge clk);
    bus_read(16'hFF01, v); check8("b2b_done_status", v, 8'h02);

    // Overflow
    bus_write(16'hFF03, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      bus_write(16'hFF00, 8'h10 + 8'(i));
      repeat (2) @(posedge clk);
    end
    bus_read(16'hFF01, v); check8("ovf_status", v, 8'h0D);
    bus_write(16'hFF01, 8'h08);
    bus_read(16'hFF01, v); check8("ovf_clear_status", v, 8'h05);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus_read(16'hFF01, v); check8("flush_status", v, 8'h02);
    bus_read(16'hFF03, v); check8("flush_baud", v, 8'h67);

    // Receiver
    bus_write(16'hFF03, 8'h03);
`ifdef UART_RX_EN
    send_rx(8'h3C, 1'b1);
    repeat (8) @(posedge clk);
    bus_read(16'hFF01, v); check8("rx1_flags", v & 8'h70, 8'h10);
    bus_read(16'hFF02, v); check8("rx1_data", v, 8'h3C);
    send_rx(8'h11, 1'b1);
    repeat (8) @(posedge clk);
    bus_read(16'hFF01, v); check8("rx2_flags", v & 8'h70, 8'h30);
    bus_read(16'hFF02, v); check8("rx2_data", v, 8'h3C);
    bus_write(16'hFF01, 8'h20);
    bus_write(16'hFF02, 8'h00);
    bus_read(16'hFF01, v); check8("rx_clear_flags", v & 8'h70, 8'h00);
    send_rx(8'h55, 1'b0);
    repeat (8) @(posedge clk);
    bus_read(16'hFF01, v); check8("rx3_flags", v & 8'h70, 8'h50);
    bus_read(16'hFF02, v); check8("rx3_data", v, 8'h55);
`else
    send_rx(8'h3C, 1'b1);
    repeat (8) @(posedge clk);
    bus_read(16'hFF01, v); check8("norx_status", v, 8'h02);
    bus_read(16'hFF02, v); check8("norx_data", v, 8'h00);
    bus_write(16'hFF02, 8'hAA);
    bus_read(16'hFF02, v); check8("norx_data_wr", v, 8'h00);
`endif

    // Reset during DATA bit 3 of 0xF0
    bus_write(16'hFF00, 8'hF0);
    bif.addr = 16'hFF01;
    repeat (18) @(posedge clk);
    #1 check8("bit3_tx", {7'd0, tx}, 8'h00);
    rst = 1'b1;
    #1 check8("rst_tx_now", {7'd0, tx}, 8'h01);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check8("rst_release_status", data, 8'h02);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check8("no_residual_tx", {7'd0, tx}, 8'h01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
